// File: rtl/cnn_pkg.sv
// Shared types and width helpers for the sequential CNN classifier.
package cnn_pkg;

    // Frame-level phases: collect pixels, convolve, pool, present result
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CONV = 2'd1,
        ST_POOL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits needed to index n items; never less than one bit
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Accumulator wide enough for K*K signed products of pixel x weight
    function automatic int acc_width(input int ip_w, input int wt_w, input int k);
        return ip_w + wt_w + $clog2(k * k) + 1;
    endfunction

    // Score wide enough to sum RW*RW pooled maxima without overflow
    function automatic int score_width(input int acc_w, input int rw);
        return acc_w + $clog2(rw * rw);
    endfunction

endpackage

// File: rtl/cnn_seq_if.sv
// Pixel stream and classification result bundle for cnn_seq_top.
interface cnn_seq_if #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int CLS_WIDTH     = 1,
    parameter int SCORE_WIDTH   = 23
);
    logic [IP_DATA_WIDTH-1:0]      pix_in;
    logic                          pix_valid;
    logic                          pix_ready;
    logic [CLS_WIDTH-1:0]          op_class;
    logic signed [SCORE_WIDTH-1:0] op_score;
    logic                          op_data_valid;
    logic                          op_ready;
    logic                          busy;

    modport master (
        output pix_in, pix_valid, op_ready,
        input  pix_ready, op_class, op_score, op_data_valid, busy
    );

    modport slave (
        input  pix_in, pix_valid, op_ready,
        output pix_ready, op_class, op_score, op_data_valid, busy
    );
endinterface

// File: rtl/cnn_mac.sv
// Signed multiply-accumulate with clear/enable and a ReLU view of the running sum.
module cnn_mac #(
    parameter int IN_WIDTH  = 8,
    parameter int WT_WIDTH  = 8,
    parameter int ACC_WIDTH = 21
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic [IN_WIDTH-1:0]        pix,
    input  logic signed [WT_WIDTH-1:0] wt,
    output logic [ACC_WIDTH-1:0]       relu_sum
);
    localparam int PW = IN_WIDTH + WT_WIDTH + 1;

    logic signed [IN_WIDTH:0]    pix_s;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;

    // Sum including the current tap, so the final tap's result is usable in the same cycle
    always_comb begin
        pix_s    = {1'b0, pix};
        prod     = PW'(pix_s) * PW'(wt);
        prod_ext = ACC_WIDTH'(prod);
        acc_next = (clr ? '0 : acc) + prod_ext;
        relu_sum = acc_next[ACC_WIDTH-1] ? '0 : acc_next;
    end

    // Running accumulator; clr restarts the sum with the current product
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end
endmodule

// File: rtl/cnn_seq_top.sv
// Sequential single-MAC CNN: load image, convolve all filters, max-pool into
// per-filter scores, and report the arg-max filter.
module cnn_seq_top
    import cnn_pkg::*;
#(
    parameter int IP_DATA_WIDTH    = 8,
    parameter int WT_WIDTH         = 8,
    parameter int IFMAP_SIZE       = 5,
    parameter int FILTER_SIZE      = 3,
    parameter int NUM_FILTERS      = 2,
    parameter int POOL_FILTER_SIZE = 2,
    parameter int POOL_STRIDE      = 1
) (
    input logic                       clk,
    input logic                       rst,
    cnn_seq_if.slave                  bus,
    input logic signed [WT_WIDTH-1:0] wt [NUM_FILTERS][FILTER_SIZE][FILTER_SIZE]
);
    localparam int OFMAP_SIZE   = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int RESULT_WIDTH = (OFMAP_SIZE - POOL_FILTER_SIZE) / POOL_STRIDE + 1;
    localparam int ACC_WIDTH    = acc_width(IP_DATA_WIDTH, WT_WIDTH, FILTER_SIZE);
    localparam int SCORE_WIDTH  = score_width(ACC_WIDTH, RESULT_WIDTH);
    localparam int IMG_PIX      = IFMAP_SIZE * IFMAP_SIZE;
    localparam int IMG_AW       = idx_width(IMG_PIX);
    localparam int F_W          = idx_width(NUM_FILTERS);
    localparam int OF_W         = idx_width(OFMAP_SIZE);
    localparam int K_W          = idx_width(FILTER_SIZE);
    localparam int RW_W         = idx_width(RESULT_WIDTH);
    localparam int P_W          = idx_width(POOL_FILTER_SIZE);

    localparam logic [IMG_AW-1:0] PIX_LAST = IMG_AW'(IMG_PIX - 1);
    localparam logic [F_W-1:0]    F_LAST   = F_W'(NUM_FILTERS - 1);
    localparam logic [OF_W-1:0]   OF_LAST  = OF_W'(OFMAP_SIZE - 1);
    localparam logic [K_W-1:0]    K_LAST   = K_W'(FILTER_SIZE - 1);
    localparam logic [RW_W-1:0]   RW_LAST  = RW_W'(RESULT_WIDTH - 1);
    localparam logic [P_W-1:0]    P_LAST   = P_W'(POOL_FILTER_SIZE - 1);

    state_t state, next_state;

    logic [IP_DATA_WIDTH-1:0] img   [IMG_PIX];
    logic [ACC_WIDTH-1:0]     ofmap [NUM_FILTERS][OFMAP_SIZE][OFMAP_SIZE];
    logic [SCORE_WIDTH-1:0]   score [NUM_FILTERS];

    logic [IMG_AW-1:0] pix_cnt;
    logic [F_W-1:0]    cf, pf;
    logic [OF_W-1:0]   cr, cc;
    logic [K_W-1:0]    kr, kc;
    logic [RW_W-1:0]   wr, wc;
    logic [P_W-1:0]    pr, pc;

    logic                     pix_fire, load_last, out_fire;
    logic                     tap_last, conv_last, win_end, pool_last;
    logic [IMG_AW-1:0]        pix_addr;
    logic [IP_DATA_WIDTH-1:0] mac_pix;
    logic signed [WT_WIDTH-1:0] mac_wt;
    logic [ACC_WIDTH-1:0]     relu_sum;
    logic [OF_W-1:0]          pool_row, pool_col;
    logic [ACC_WIDTH-1:0]     pool_val, win_max, cur_max;
    logic [F_W-1:0]           best_idx;
    logic [SCORE_WIDTH-1:0]   best_score;
    logic                     pix_ready_int, busy_int;
    logic                     out_valid;
    logic [F_W-1:0]           out_class;
    logic [SCORE_WIDTH-1:0]   out_score;

    // Handshake qualifiers, end-of-loop flags and buffer addressing
    always_comb begin
        pix_fire  = (state == ST_LOAD) && bus.pix_valid;
        load_last = pix_fire && (pix_cnt == PIX_LAST);
        out_fire  = out_valid && bus.op_ready;
        tap_last  = (kr == K_LAST) && (kc == K_LAST);
        conv_last = (state == ST_CONV) && tap_last && (cf == F_LAST) &&
                    (cr == OF_LAST) && (cc == OF_LAST);
        win_end   = (pr == P_LAST) && (pc == P_LAST);
        pool_last = (state == ST_POOL) && win_end && (pf == F_LAST) &&
                    (wr == RW_LAST) && (wc == RW_LAST);
        pix_addr  = IMG_AW'((int'(cr) + int'(kr)) * IFMAP_SIZE + int'(cc) + int'(kc));
        mac_pix   = img[pix_addr];
        mac_wt    = wt[cf][kr][kc];
        pool_row  = OF_W'(int'(wr) * POOL_STRIDE + int'(pr));
        pool_col  = OF_W'(int'(wc) * POOL_STRIDE + int'(pc));
        pool_val  = ofmap[pf][pool_row][pool_col];
        cur_max   = ((pr == '0) && (pc == '0)) ? pool_val :
                    ((pool_val > win_max) ? pool_val : win_max);
    end

    // Arg-max over filter scores; strict compare keeps the lowest index on ties
    always_comb begin
        best_idx   = '0;
        best_score = score[0];
        for (int f = 1; f < NUM_FILTERS; f++) begin
            if (score[f] > best_score) begin
                best_score = score[f];
                best_idx   = F_W'(f);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_LOAD;
        else      state <= next_state;
    end

    // Phase sequencing plus the ready/busy flags that depend only on phase
    always_comb begin
        next_state    = state;
        pix_ready_int = 1'b0;
        busy_int      = 1'b0;
        unique case (state)
            ST_LOAD: begin
                pix_ready_int = 1'b1;
                if (load_last) next_state = ST_CONV;
            end
            ST_CONV: begin
                busy_int = 1'b1;
                if (conv_last) next_state = ST_POOL;
            end
            ST_POOL: begin
                busy_int = 1'b1;
                if (pool_last) next_state = ST_DONE;
            end
            ST_DONE: begin
                if (out_fire) next_state = ST_LOAD;
            end
            default: next_state = ST_LOAD;
        endcase
    end

    // Image buffer; contents are simply overwritten by the next frame
    always_ff @(posedge clk) begin
        if (pix_fire) img[pix_addr_load()] <= bus.pix_in;
    end

    function automatic logic [IMG_AW-1:0] pix_addr_load();
        return pix_cnt;
    endfunction

    // Feature-map buffer written with the clamped sum on each output's final tap
    always_ff @(posedge clk) begin
        if ((state == ST_CONV) && tap_last) ofmap[cf][cr][cc] <= relu_sum;
    end

    // Pixel counter: only accepted pixels advance it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt <= '0;
        end else if (pix_fire) begin
            pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
        end
    end

    // Convolution loop nest: filter, row, column, then K*K taps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cf <= '0; cr <= '0; cc <= '0; kr <= '0; kc <= '0;
        end else if (state == ST_CONV) begin
            if (kc != K_LAST) begin
                kc <= kc + 1'b1;
            end else begin
                kc <= '0;
                if (kr != K_LAST) begin
                    kr <= kr + 1'b1;
                end else begin
                    kr <= '0;
                    if (cc != OF_LAST) begin
                        cc <= cc + 1'b1;
                    end else begin
                        cc <= '0;
                        if (cr != OF_LAST) begin
                            cr <= cr + 1'b1;
                        end else begin
                            cr <= '0;
                            cf <= (cf == F_LAST) ? '0 : cf + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Pooling loop nest: running window max, folded into the filter score at window end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pf <= '0; wr <= '0; wc <= '0; pr <= '0; pc <= '0;
            win_max <= '0;
            for (int f = 0; f < NUM_FILTERS; f++) score[f] <= '0;
        end else if (load_last) begin
            for (int f = 0; f < NUM_FILTERS; f++) score[f] <= '0;
        end else if (state == ST_POOL) begin
            win_max <= cur_max;
            if (win_end) score[pf] <= score[pf] + SCORE_WIDTH'(cur_max);
            if (pc != P_LAST) begin
                pc <= pc + 1'b1;
            end else begin
                pc <= '0;
                if (pr != P_LAST) begin
                    pr <= pr + 1'b1;
                end else begin
                    pr <= '0;
                    if (wc != RW_LAST) begin
                        wc <= wc + 1'b1;
                    end else begin
                        wc <= '0;
                        if (wr != RW_LAST) begin
                            wr <= wr + 1'b1;
                        end else begin
                            wr <= '0;
                            pf <= (pf == F_LAST) ? '0 : pf + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Result register: captures the arg-max one cycle into DONE and holds it until accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
        end else if ((state == ST_DONE) && !out_valid) begin
            out_valid <= 1'b1;
            out_class <= best_idx;
            out_score <= best_score;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    cnn_mac #(
        .IN_WIDTH (IP_DATA_WIDTH),
        .WT_WIDTH (WT_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_CONV),
        .clr     ((kr == '0) && (kc == '0)),
        .pix     (mac_pix),
        .wt      (mac_wt),
        .relu_sum(relu_sum)
    );

    assign bus.pix_ready     = pix_ready_int;
    assign bus.busy          = busy_int;
    assign bus.op_data_valid = out_valid;
    assign bus.op_class      = out_class;
    assign bus.op_score      = out_score;
endmodule

// File: tb/tb_cnn_seq_top.sv
// Scoreboard bench for cnn_seq_top: directed frames with hand-derived results
// and random frames checked against a loop-level reference model.
module tb_cnn_seq_top;
    import cnn_pkg::*;

    localparam int IP_DATA_WIDTH    = 8;
    localparam int WT_WIDTH         = 8;
    localparam int IFMAP_SIZE       = 5;
    localparam int FILTER_SIZE      = 3;
    localparam int NUM_FILTERS      = 2;
    localparam int POOL_FILTER_SIZE = 2;
    localparam int POOL_STRIDE      = 1;
    localparam int OFMAP_SIZE   = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int RESULT_WIDTH = (OFMAP_SIZE - POOL_FILTER_SIZE) / POOL_STRIDE + 1;
    localparam int ACC_WIDTH    = acc_width(IP_DATA_WIDTH, WT_WIDTH, FILTER_SIZE);
    localparam int SCORE_WIDTH  = score_width(ACC_WIDTH, RESULT_WIDTH);
    localparam int CLS_WIDTH    = idx_width(NUM_FILTERS);
    localparam int IMG_PIX      = IFMAP_SIZE * IFMAP_SIZE;
    localparam int LATENCY      = NUM_FILTERS * (OFMAP_SIZE * OFMAP_SIZE * FILTER_SIZE * FILTER_SIZE +
                                  RESULT_WIDTH * RESULT_WIDTH * POOL_FILTER_SIZE * POOL_FILTER_SIZE) + 1;

    typedef struct {
        int     cls;
        longint score;
        int     hs_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic signed [WT_WIDTH-1:0] wt [NUM_FILTERS][FILTER_SIZE][FILTER_SIZE];
    int   img_arr [IMG_PIX];
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    exp_t exp_q [$];
    exp_t cur;
    logic prev_valid = 1'b0;

    cnn_seq_if #(
        .IP_DATA_WIDTH(IP_DATA_WIDTH),
        .CLS_WIDTH    (CLS_WIDTH),
        .SCORE_WIDTH  (SCORE_WIDTH)
    ) bus ();

    cnn_seq_top #(
        .IP_DATA_WIDTH   (IP_DATA_WIDTH),
        .WT_WIDTH        (WT_WIDTH),
        .IFMAP_SIZE      (IFMAP_SIZE),
        .FILTER_SIZE     (FILTER_SIZE),
        .NUM_FILTERS     (NUM_FILTERS),
        .POOL_FILTER_SIZE(POOL_FILTER_SIZE),
        .POOL_STRIDE     (POOL_STRIDE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .wt (wt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic signed [63:0] actual,
                                input logic signed [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: pops an expectation when a result appears, then checks it stays put
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.op_data_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_output", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check_output("op_class", bus.op_class, cur.cls);
                    check_output("op_score", bus.op_score, cur.score);
                    check_output("latency", cyc - cur.hs_cyc, LATENCY);
                end
            end else if (bus.op_data_valid) begin
                check_output("held_class", bus.op_class, cur.cls);
                check_output("held_score", bus.op_score, cur.score);
            end
            prev_valid = bus.op_data_valid;
        end
    end

    task automatic fill_image(input int v);
        for (int i = 0; i < IMG_PIX; i++) img_arr[i] = v;
    endtask

    task automatic set_weights(input int f, input int v);
        for (int r = 0; r < FILTER_SIZE; r++)
            for (int c = 0; c < FILTER_SIZE; c++)
                wt[f][r][c] = WT_WIDTH'(v);
    endtask

    // Reference: direct convolution, ReLU, window max, per-filter sum, first arg-max
    function automatic void model(output int cls, output longint best);
        longint sc [NUM_FILTERS];
        longint mx, conv;
        int r, c;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            sc[f] = 0;
            for (int wr = 0; wr < RESULT_WIDTH; wr++) begin
                for (int wc = 0; wc < RESULT_WIDTH; wc++) begin
                    mx = 0;
                    for (int pr = 0; pr < POOL_FILTER_SIZE; pr++) begin
                        for (int pc = 0; pc < POOL_FILTER_SIZE; pc++) begin
                            r = wr * POOL_STRIDE + pr;
                            c = wc * POOL_STRIDE + pc;
                            conv = 0;
                            for (int kr = 0; kr < FILTER_SIZE; kr++)
                                for (int kc = 0; kc < FILTER_SIZE; kc++)
                                    conv += longint'(img_arr[(r + kr) * IFMAP_SIZE + c + kc]) *
                                            longint'(wt[f][kr][kc]);
                            if (conv < 0) conv = 0;
                            if (conv > mx) mx = conv;
                        end
                    end
                    sc[f] += mx;
                end
            end
        end
        cls  = 0;
        best = sc[0];
        for (int f = 1; f < NUM_FILTERS; f++) begin
            if (sc[f] > best) begin
                best = sc[f];
                cls  = f;
            end
        end
    endfunction

    // Streams img_arr; mode 0 back-to-back, 1 alternating valid, 2 random gaps
    task automatic apply_stimulus(input int mode, input int exp_cls, input longint exp_score);
        exp_t e;
        int   wait_n;
        for (int i = 0; i < IMG_PIX; i++) begin
            if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(99) < 30)) begin
                bus.pix_valid = 1'b0;
                bus.pix_in    = IP_DATA_WIDTH'($urandom);
                @(posedge clk); #1;
            end
            wait_n = 0;
            while (!bus.pix_ready && wait_n < 400) begin
                @(posedge clk); #1;
                wait_n++;
            end
            if (!bus.pix_ready) begin
                check_output("pix_ready_timeout", 0, 1);
                bus.pix_valid = 1'b0;
                return;
            end
            bus.pix_in    = IP_DATA_WIDTH'(img_arr[i]);
            bus.pix_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        e.cls    = exp_cls;
        e.score  = exp_score;
        e.hs_cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Waits for the result, stalls op_ready for 'hold' cycles, then accepts it
    task automatic collect_output(input int hold);
        int budget;
        check_output("busy_in_compute", bus.busy, 1);
        check_output("pix_ready_in_compute", bus.pix_ready, 0);
        budget = 0;
        while (!bus.op_data_valid && budget < LATENCY + 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus.op_data_valid) begin
            check_output("output_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check_output("pix_ready_in_done", bus.pix_ready, 0);
            check_output("busy_in_done", bus.busy, 0);
            @(posedge clk); #1;
        end
        check_output("valid_before_accept", bus.op_data_valid, 1);
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        check_output("valid_after_accept", bus.op_data_valid, 0);
        check_output("pix_ready_after_accept", bus.pix_ready, 1);
    endtask

    initial begin
        int     m_cls;
        longint m_score;

        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.op_ready  = 1'b0;
        for (int f = 0; f < NUM_FILTERS; f++) set_weights(f, 0);

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_valid", bus.op_data_valid, 0);
        check_output("reset_busy", bus.busy, 0);
        check_output("reset_class", bus.op_class, 0);
        check_output("reset_score", bus.op_score, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("reset_pix_ready", bus.pix_ready, 1);

        $display("[TB] directed: unit image, filters 1 and 2");
        fill_image(1); set_weights(0, 1); set_weights(1, 2);
        apply_stimulus(0, 1, 72);
        collect_output(2);

        $display("[TB] directed: negative filter clamped by ReLU");
        set_weights(1, -1);
        apply_stimulus(0, 0, 36);
        collect_output(0);

        $display("[TB] directed: identical filters tie");
        set_weights(1, 1);
        apply_stimulus(0, 0, 36);
        collect_output(1);

        $display("[TB] directed: full-scale pixels and weights");
        fill_image(255); set_weights(0, 127); set_weights(1, 127);
        apply_stimulus(0, 0, 1165860);
        collect_output(0);

        $display("[TB] directed: all-negative weights give zero scores");
        set_weights(0, -1); set_weights(1, -1);
        apply_stimulus(2, 0, 0);
        collect_output(0);

        $display("[TB] directed: toggling pix_valid and stalled op_ready");
        fill_image(1); set_weights(0, 1); set_weights(1, 2);
        apply_stimulus(1, 1, 72);
        collect_output(10);

        $display("[TB] directed: reset during compute discards frame");
        apply_stimulus(0, 1, 72);
        repeat (49) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        #2;
        check_output("abort_valid", bus.op_data_valid, 0);
        check_output("abort_busy", bus.busy, 0);
        check_output("abort_score", bus.op_score, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("abort_pix_ready", bus.pix_ready, 1);
        apply_stimulus(0, 1, 72);
        collect_output(0);

        $display("[TB] random frames");
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < IMG_PIX; i++) img_arr[i] = int'($urandom_range(255));
            for (int f = 0; f < NUM_FILTERS; f++)
                for (int r = 0; r < FILTER_SIZE; r++)
                    for (int c = 0; c < FILTER_SIZE; c++)
                        wt[f][r][c] = WT_WIDTH'($urandom_range(255));
            model(m_cls, m_score);
            apply_stimulus(2, m_cls, m_score);
            collect_output(int'($urandom_range(4)));
        end

        repeat (20) @(posedge clk);
        #1;
        check_output("pending_expected", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/cnn_seq_top.md
CNN_SEQ_TOP -- requirements
Module: cnn_seq_top

Interface
REQ-001 SHALL have parameter IP_DATA_WIDTH, default 8, unsigned pixel width.
REQ-002 SHALL have parameter WT_WIDTH, default 8, signed weight width.
REQ-003 SHALL have parameter IFMAP_SIZE, default 5, square input edge.
REQ-004 SHALL have parameter FILTER_SIZE (K), default 3, square filter edge; conv stride fixed at 1.
REQ-005 SHALL have parameter NUM_FILTERS, default 2, number of output channels/classes.
REQ-006 SHALL have parameters POOL_FILTER_SIZE (P), default 2, and POOL_STRIDE, default 1.
REQ-007 SHALL derive OFMAP_SIZE=IFMAP_SIZE-K+1, RESULT_WIDTH (RW)=(OFMAP_SIZE-P)/POOL_STRIDE+1, ACC_WIDTH=IP_DATA_WIDTH+WT_WIDTH+$clog2(K*K)+1, SCORE_WIDTH=ACC_WIDTH+$clog2(RW*RW), CLS_WIDTH=max(1,$clog2(NUM_FILTERS)).
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-low reset; pix_in in IP_DATA_WIDTH raster-order pixel; pix_valid in 1; pix_ready out 1; wt in signed WT_WIDTH [NUM_FILTERS][K][K], stable while busy; op_class out CLS_WIDTH winning filter index; op_score out signed SCORE_WIDTH winning score; op_data_valid out 1; op_ready in 1; busy out 1.

Function
REQ-009 SHALL implement FSM LOAD -> CONV -> POOL -> DONE -> LOAD.
REQ-010 LOAD: pix_ready=1; pixel stored on each cycle pix_valid&pix_ready; after IFMAP_SIZE^2 handshakes go to CONV; pix_valid low cycles do not advance the count.
REQ-011 pix_ready SHALL be 0 in CONV, POOL, DONE; pix_valid then ignored.
REQ-012 CONV: one signed MAC per cycle, order filter f, row r, col c, tap; K*K cycles per output; result ReLU-clamped (negative -> 0) and written to ofmap buffer [f][r][c].
REQ-013 POOL: per filter, per window, one compare per cycle (P*P cycles/window); window max added to score[f]; score accumulation exact, no saturation.
REQ-014 Compute cycles C=NUM_FILTERS*(OFMAP_SIZE^2*K*K + RW^2*P*P); op_data_valid SHALL rise exactly C+1 cycles after the last pixel handshake (C=194 at defaults).
REQ-015 op_class = argmax score[f]; ties -> lowest index; all-zero scores -> class 0, score 0.
REQ-016 DONE: op_data_valid=1, op_class/op_score held stable until op_ready=1; on that handshake cycle return to LOAD, pix_ready=1 next cycle.
REQ-017 busy=1 in CONV and POOL only.
REQ-018 Pixels treated unsigned, zero-extended; weights signed; products and sums sign-extended to ACC_WIDTH.

Reset
REQ-019 On rst=0, asynchronously: state LOAD, all counters 0, scores 0, op_data_valid 0, op_class 0, op_score 0, busy 0; pix_ready 1 after release.
REQ-020 Reset mid-frame SHALL discard the frame; no op_data_valid for it; image/ofmap buffer contents need not be cleared.

Structure
REQ-021 Package cnn_pkg SHALL hold the FSM state enum and width helper functions (acc/score width).
REQ-022 One sub-module cnn_mac (signed MAC with clear/enable, ReLU output) SHALL be instantiated; buffers, counters, pooling, argmax in top.

Verification
REQ-023 All pixels 1, filter0 all 1, filter1 all 2 -> op_class=1, op_score=72 (score0=36), op_data_valid 195 cycles after last pixel.
REQ-024 Same image, filter0 all 1, filter1 all -1 -> ReLU zeros filter1; op_class=0, op_score=36.
REQ-025 Identical filters (all 1) -> tie -> op_class=0, op_score=36.
REQ-026 All pixels 255, all weights 127 -> each conv 291465, op_score=1165860, no overflow; op_class=0.
REQ-027 pix_valid toggling 1/0 during LOAD, then op_ready held 0 for 10 cycles in DONE -> only 25 handshakes counted, outputs stable, pix_ready=0 until handshake.
REQ-028 rst asserted at compute cycle 50, new frame (test REQ-023) loaded -> no output from aborted frame; op_class=1, op_score=72.
